// File: rtl/program_memory_ctrl_if.sv
// program_memory_ctrl_if: fetch port, loader/debug write port and init status.
// master drives requests/writes; slave is the memory and returns fetch results.
interface program_memory_ctrl_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_error;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        init_busy;

  modport master (
    output fetch_req, fetch_addr,
    output wr_en, wr_addr, wr_strb, wr_data,
    input  fetch_ready, fetch_valid,
    input  fetch_data, fetch_error,
    input  init_busy
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  wr_en, wr_addr, wr_strb, wr_data,
    output fetch_ready, fetch_valid,
    output fetch_data, fetch_error,
    output init_busy
  );
endinterface

// File: rtl/program_memory_ctrl.sv
// program_memory_ctrl: instruction memory, 1-cycle registered fetch, byte writes.
// Ports: clk, rst_n (async low), bus (slave): fetch_req/addr/ready/valid/data/
//   error, wr_en/addr/strb/data, init_busy.
// Macro PROGRAM_MEMORY_BOOT_FILL_EN: fill every word with NOP_WORD after reset.
module program_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  rst_n,
  program_memory_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic {S_FILL, S_READY} state_t;

  logic [31:0] r_mem [DEPTH_WORDS];
  state_t      r_state;
  logic        r_ready;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_data;

  logic [AW-1:0] w_f_idx;
  logic [AW-1:0] w_w_idx;
  logic          w_f_acc;
  logic          w_f_ok;
  logic          w_wr_ok;
  logic          w_hit;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  assign w_f_idx = bus.fetch_addr[AW+1:2];
  assign w_w_idx = bus.wr_addr[AW+1:2];
  assign w_f_acc = bus.fetch_req && r_ready;

  // range checks use the full 33-bit compare so high bits never alias
  assign w_f_ok  = ({1'b0, bus.fetch_addr} < LIMIT)
                && (bus.fetch_addr[1:0] == 2'b00);
  assign w_wr_ok = bus.wr_en && r_ready
                && ({1'b0, bus.wr_addr} < LIMIT);
  assign w_hit   = w_wr_ok && (w_w_idx == w_f_idx);

  // write-first: strobed bytes of a same-word write bypass the array
  always_comb begin
    w_rd_word = r_mem[w_f_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_hit && bus.wr_strb[i]) begin
        w_rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  assign w_unused = ^bus.wr_addr[1:0];

`ifdef PROGRAM_MEMORY_BOOT_FILL_EN
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (r_cnt == LAST) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        S_READY: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.init_busy = r_busy;

  always_ff @(posedge clk) begin
    if (r_state == S_FILL) begin
      r_mem[r_cnt] <= NOP_WORD;
    end
    if (w_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wr_strb[i]) begin
          r_mem[w_w_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_READY;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (r_state == S_READY);
    end
  end

  assign bus.init_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wr_strb[i]) begin
          r_mem[w_w_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= NOP_WORD;
    end else if (w_f_acc) begin
      r_valid <= 1'b1;
      r_err   <= !w_f_ok;
      r_data  <= w_f_ok ? w_rd_word : NOP_WORD;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.fetch_ready = r_ready;
  assign bus.fetch_valid = r_valid;
  assign bus.fetch_data  = r_data;
  assign bus.fetch_error = r_err;

endmodule

// File: tb/tb_program_memory_ctrl.sv
// tb_program_memory_ctrl: directed stimulus with a scoreboard queue and
// a negedge monitor that checks every fetch_valid pulse.
module tb_program_memory_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  program_memory_ctrl_if ifc ();

  program_memory_ctrl #(
    .DEPTH_WORDS(32),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.fetch_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=%b data %h expected no result",
                 ifc.fetch_valid, ifc.fetch_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fetch_data", ifc.fetch_data, mon_e[31:0]);
        chk("fetch_error", {31'b0, ifc.fetch_error}, {31'b0, mon_e[32]});
      end
    end
  end

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic e);
    ifc.fetch_req  = 1'b1;
    ifc.fetch_addr = a;
    exp_q.push_back({e, d});
    @(posedge clk);
    #1;
    ifc.fetch_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [3:0] s,
                    input logic [31:0] d);
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = a;
    ifc.wr_strb = s;
    ifc.wr_data = d;
    @(posedge clk);
    #1;
    ifc.wr_en   = 1'b0;
    ifc.wr_strb = 4'h0;
  endtask

  task automatic wr_fetch(input logic [31:0] a,
                          input logic [3:0] s,
                          input logic [31:0] d,
                          input logic [31:0] ed);
    ifc.wr_en      = 1'b1;
    ifc.wr_addr    = a;
    ifc.wr_strb    = s;
    ifc.wr_data    = d;
    ifc.fetch_req  = 1'b1;
    ifc.fetch_addr = a;
    exp_q.push_back({1'b0, ed});
    @(posedge clk);
    #1;
    ifc.wr_en     = 1'b0;
    ifc.wr_strb   = 4'h0;
    ifc.fetch_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input logic busy);
    chk("rst_ready", {31'b0, ifc.fetch_ready}, 32'd0);
    chk("rst_valid", {31'b0, ifc.fetch_valid}, 32'd0);
    chk("rst_data", ifc.fetch_data, NOP);
    chk("rst_error", {31'b0, ifc.fetch_error}, 32'd0);
    chk("rst_busy", {31'b0, ifc.init_busy}, {31'b0, busy});
  endtask

  task automatic boot_phase();
`ifdef PROGRAM_MEMORY_BOOT_FILL_EN
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("fill_busy", {31'b0, ifc.init_busy}, 32'd1);
      chk("fill_ready", {31'b0, ifc.fetch_ready}, 32'd0);
    end
    @(negedge clk);
    chk("ready_after_fill", {31'b0, ifc.fetch_ready}, 32'd1);
    chk("busy_after_fill", {31'b0, ifc.init_busy}, 32'd0);
`else
    @(negedge clk);
    chk("ready_pre_edge", {31'b0, ifc.fetch_ready}, 32'd0);
    chk("busy_nofill", {31'b0, ifc.init_busy}, 32'd0);
    @(negedge clk);
    chk("ready_post_edge", {31'b0, ifc.fetch_ready}, 32'd1);
`endif
  endtask

  initial begin
    ifc.fetch_req  = 1'b0;
    ifc.fetch_addr = 32'h0;
    ifc.wr_en      = 1'b0;
    ifc.wr_addr    = 32'h0;
    ifc.wr_strb    = 4'h0;
    ifc.wr_data    = 32'h0;
    #12;
`ifdef PROGRAM_MEMORY_BOOT_FILL_EN
    chk_reset(1'b1);
`else
    chk_reset(1'b0);
`endif
    // requests held high across boot must all be ignored
    ifc.fetch_req  = 1'b1;
    ifc.fetch_addr = 32'h0000_000C;
    ifc.wr_en      = 1'b1;
    ifc.wr_addr    = 32'h0000_000C;
    ifc.wr_strb    = 4'hF;
    ifc.wr_data    = 32'hFFFF_FFFF;
`ifndef PROGRAM_MEMORY_BOOT_FILL_EN
    ifc.fetch_req  = 1'b0;
    ifc.wr_en      = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot_phase();
    ifc.fetch_req = 1'b0;
    ifc.wr_en     = 1'b0;
    ifc.wr_strb   = 4'h0;
`ifndef PROGRAM_MEMORY_BOOT_FILL_EN
    for (int k = 0; k < 32; k++) begin
      wr(32'(k * 4), 4'hF, NOP);
    end
`endif

    fetch(32'h0000_0000, NOP, 1'b0);
    fetch(32'h0000_007C, NOP, 1'b0);
    fetch(32'h0000_000C, NOP, 1'b0);

    wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    wr(32'h0000_0012, 4'b0010, 32'h0000_AA00);
    fetch(32'h0000_0010, 32'hDEAD_AAEF, 1'b0);
    idle(2);
    chk("hold_data", ifc.fetch_data, 32'hDEAD_AAEF);
    chk("hold_valid", {31'b0, ifc.fetch_valid}, 32'd0);

    wr_fetch(32'h0000_0008, 4'hF, 32'h1234_5678, 32'h1234_5678);
    wr_fetch(32'h0000_0008, 4'b1001, 32'hAB00_00CD, 32'hAB34_56CD);
    wr(32'h0000_0014, 4'h0, 32'h5555_5555);

    fetch(32'h0000_0006, NOP, 1'b1);
    idle(2);
    chk("hold_error", {31'b0, ifc.fetch_error}, 32'd1);
    chk("hold_err_data", ifc.fetch_data, NOP);
    fetch(32'h0000_0080, NOP, 1'b1);
    fetch(32'hFFFF_FFFC, NOP, 1'b1);
    fetch(32'h1000_0010, NOP, 1'b1);
    wr(32'h0000_0080, 4'hF, 32'h5555_5555);
    fetch(32'h0000_0000, NOP, 1'b0);

    fetch(32'h0000_0010, 32'hDEAD_AAEF, 1'b0);
    fetch(32'h0000_0008, 32'hAB34_56CD, 1'b0);
    fetch(32'h0000_0014, NOP, 1'b0);
    fetch(32'h0000_0011, NOP, 1'b1);
    fetch(32'h0000_0004, NOP, 1'b0);
    idle(2);

    // result in flight when reset hits is dropped
    ifc.fetch_req  = 1'b1;
    ifc.fetch_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    ifc.fetch_req = 1'b0;
    rst_n = 1'b0;
    #1;
`ifdef PROGRAM_MEMORY_BOOT_FILL_EN
    chk_reset(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midfill_busy", {31'b0, ifc.init_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot_phase();
    fetch(32'h0000_0010, NOP, 1'b0);
    fetch(32'h0000_0008, NOP, 1'b0);
`else
    chk_reset(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot_phase();
`endif
    fetch(32'h0000_0080, NOP, 1'b1);
    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_memory_ctrl.md
# program_memory_ctrl

Parametrised instruction memory for the RISC-V core's fetch stage. It holds DEPTH_WORDS 32-bit words and serves byte-addressed fetches with one-cycle registered read latency and a valid strobe. A byte-strobed write port is provided for the loader and debug path. Out-of-range and misaligned fetches are flagged. An optional boot-fill state machine initialises every word to a NOP after reset.

## Interface
Parameters:
- DEPTH_WORDS, 32, number of 32-bit words; power of two, ≥ 2.
- NOP_WORD, 32'h0000_0013, word returned on error and used for boot fill (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  fetch byte address (PC).
- fetch_ready  out  1  fetches accepted when high.
- fetch_valid  out  1  fetch_data/fetch_error valid this cycle.
- fetch_data  out  32  fetched instruction word.
- fetch_error  out  1  accepted fetch was misaligned or out of range.
- wr_en  in  1  write request.
- wr_addr  in  32  write byte address; bits [1:0] ignored.
- wr_strb  in  4  byte enables; bit i writes wr_data[8i+7:8i].
- wr_data  in  32  write data.
- init_busy  out  1  boot fill in progress.

## Operation
- Word index = addr[$clog2(DEPTH_WORDS)+1:2]. An address is in range iff addr < DEPTH_WORDS*4.
- A fetch is accepted when fetch_req && fetch_ready.
- Accepted fetch that is in range and has addr[1:0]==0:
  - next cycle: fetch_data = mem[index], fetch_error=0.
- Accepted fetch that is misaligned (addr[1:0]!=0) or out of range:
  - next cycle: fetch_data = NOP_WORD, fetch_error=1; memory is not read.
- Cycle with no accepted fetch: next cycle fetch_valid=0; fetch_data and fetch_error hold their previous values.
- Write: when wr_en && fetch_ready, each byte with wr_strb[i]=1 is updated at the rising edge.
  - Out-of-range writes are dropped.
  - wr_strb=0 is a no-op.
- Read-during-write to the same word in the same cycle is write-first: fetch_data returns the merged word (new bytes where strobed, old bytes elsewhere).
- State machine: FILL → READY.
  - FILL: a counter walks 0..DEPTH_WORDS-1, writing NOP_WORD to one word per cycle. init_busy=1, fetch_ready=0, wr_en ignored (writes dropped, not queued).
  - FILL → READY after the write at index DEPTH_WORDS-1.
  - READY: fetch_ready=1, init_busy=0; terminal until reset.
- Reset asserted at any time, including mid-fill:
  - forces state FILL, counter 0, all outputs to reset values;
  - any in-flight fetch result is discarded;
  - with fill disabled, see Configuration.

## Timing
- Reset values: fetch_ready=0, fetch_valid=0, fetch_data=NOP_WORD, fetch_error=0, init_busy=1 (0 with fill disabled).
- Fetch latency: exactly 1 cycle, request edge to fetch_valid. Back-to-back fetches give one result per cycle.
- No back-pressure: fetch_valid is a single-cycle pulse per accepted fetch.
- Boot fill lasts DEPTH_WORDS cycles after rst_n deasserts. fetch_ready rises in cycle DEPTH_WORDS+1 (the first cycle after the last fill write).
- The fill counter is $clog2(DEPTH_WORDS) bits. It must not wrap: the transition to READY happens at count DEPTH_WORDS-1.
- Out-of-range compare uses the full 32-bit address; upper address bits are never truncated into the index.

## Configuration
- Macro: PROGRAM_MEMORY_BOOT_FILL_EN.
- Defined: FILL state and counter are present, with behaviour as above.
- Undefined:
  - No FILL state and no fill counter; init_busy is tied to 0.
  - The state register resets directly to READY, but fetch_ready is registered: it resets to 0 and rises on the first rising edge after rst_n deasserts.
  - Memory contents are undefined until written.

## Test plan
- Boot fill (macro on, DEPTH_WORDS=32): release reset → init_busy=1 and fetch_ready=0 for 32 cycles. Then fetch of 0x00, 0x7C → fetch_data=0x00000013, fetch_error=0.
- Writes and fetch: write 0xDEADBEEF to 0x10 with strb=4'hF, then strb=4'b0010 data 0x0000AA00 → fetch 0x10 returns 0xDEADAAEF one cycle later, fetch_valid pulse of width 1.
- Write-first: same cycle wr 0x08 (strb 4'hF, 0x12345678) and fetch 0x08 → next cycle fetch_data=0x12345678.
- Errors:
  - fetch 0x06 → fetch_error=1, fetch_data=0x00000013;
  - fetch 0x80 (DEPTH 32) → fetch_error=1;
  - write to 0x80 does not alias word 0.
- Reset mid-fill: assert rst_n=0 at fill count 10 → outputs at reset values immediately. Release → full 32-cycle fill restarts from index 0.
- Dropped accesses during fill: wr_en during FILL is dropped (word reads NOP_WORD after READY). fetch_req during FILL produces no fetch_valid.
